// File: rtl/gpu_framebuffer_if.sv
// Pixel-op bus between the GPU operation engine / scanout timing (master) and the
// double-buffered frame store (slave).
//  op_*          GPU pixel read/write port (back buffer), op_ram_value is read data
//  scan_*        scanout coordinate/strobe in, scan_pixel out (front buffer)
//  frame_start   start-of-vertical-blank pulse
//  swap_req      buffer swap request; swap_pending/front_sel report swap state
//  range_error   sticky out-of-range flag, cleared by err_clear
interface gpu_framebuffer_if;
    logic [8:0] op_x;
    logic [7:0] op_y;
    logic       op_ram_enable_read;
    logic       op_ram_enable_write;
    logic       op_ram_write_value;
    logic       op_ram_value;
    logic [9:0] scan_x;
    logic [9:0] scan_y;
    logic       scan_en;
    logic       frame_start;
    logic       scan_pixel;
    logic       swap_req;
    logic       swap_pending;
    logic       front_sel;
    logic       range_error;
    logic       err_clear;

    modport master (
        output op_x, op_y, op_ram_enable_read, op_ram_enable_write, op_ram_write_value,
        output scan_x, scan_y, scan_en, frame_start, swap_req, err_clear,
        input  op_ram_value, scan_pixel, swap_pending, front_sel, range_error
    );

    modport slave (
        input  op_x, op_y, op_ram_enable_read, op_ram_enable_write, op_ram_write_value,
        input  scan_x, scan_y, scan_en, frame_start, swap_req, err_clear,
        output op_ram_value, scan_pixel, swap_pending, front_sel, range_error
    );
endinterface

// File: rtl/gpu_framebuffer.sv
// Double-buffered 1-bit-per-pixel frame store.
//  clk    system clock, all logic on posedge
//  rst_n  synchronous active-low reset (memory contents are kept)
//  bus    gpu_framebuffer_if.slave: GPU pixel port on the back buffer (1-cycle read
//         latency, write-first), 2-stage scanout read of the front buffer, swap control
//         synchronised to frame_start, sticky range error.
module gpu_framebuffer #(
    parameter int unsigned WIDTH    = 320,
    parameter int unsigned HEIGHT   = 200,
    parameter int unsigned SCALE_SH = 1
) (
    input logic              clk,
    input logic              rst_n,
    gpu_framebuffer_if.slave bus
);
    localparam int unsigned Pixels = WIDTH * HEIGHT;
    localparam int unsigned IdxW   = $clog2(Pixels);

    typedef logic [16:0] offset_t;
    typedef enum logic [0:0] {StIdle, StPending} swap_state_e;

    function automatic offset_t pix_offset(input offset_t x, input offset_t y);
        if (WIDTH == 320) begin
            return (y << 8) + (y << 6) + x;
        end else begin
            return offset_t'(y * WIDTH + x);
        end
    endfunction

    // mem[bank][pixel]; bank is the buffer index, i.e. the top address bit
    logic mem [2][Pixels];

    swap_state_e state_q, state_d;
    logic        toggle;
    logic        front_sel_q;
    logic        op_ram_value_q;
    logic        range_error_q;
    logic        scan_pixel_q;
    logic [9:0]  sx_q, sy_q;
    logic        scan_en_q, scan_in_q;

    logic            back_sel;
    logic            op_in, op_we, op_err;
    offset_t         op_off, scan_off;
    logic [IdxW-1:0] op_idx, scan_idx;
    logic [9:0]      sx, sy;
    logic            scan_in;

    assign back_sel = ~front_sel_q;
    assign op_in    = (32'(bus.op_x) < WIDTH) && (32'(bus.op_y) < HEIGHT);
    assign op_off   = pix_offset(offset_t'(bus.op_x), offset_t'(bus.op_y));
    assign op_idx   = op_off[IdxW-1:0];
    assign op_we    = rst_n && bus.op_ram_enable_write && op_in;
    assign op_err   = (bus.op_ram_enable_read || bus.op_ram_enable_write) && !op_in;

    assign sx       = bus.scan_x >> SCALE_SH;
    assign sy       = bus.scan_y >> SCALE_SH;
    assign scan_in  = (32'(sx) < WIDTH) && (32'(sy) < HEIGHT);
    assign scan_off = pix_offset(offset_t'(sx_q), offset_t'(sy_q));
    assign scan_idx = scan_off[IdxW-1:0];

    // Swap FSM: requests while pending are absorbed; a request coincident with
    // frame_start in idle waits for the following frame_start.
    always_comb begin
        state_d = state_q;
        toggle  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.swap_req) state_d = StPending;
            end
            StPending: begin
                if (bus.frame_start) begin
                    state_d = StIdle;
                    toggle  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (op_we) mem[back_sel][op_idx] <= bus.op_ram_write_value;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            front_sel_q    <= 1'b0;
            op_ram_value_q <= 1'b0;
            range_error_q  <= 1'b0;
            scan_pixel_q   <= 1'b0;
            sx_q           <= '0;
            sy_q           <= '0;
            scan_en_q      <= 1'b0;
            scan_in_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            front_sel_q <= front_sel_q ^ toggle;

            // Write-first: a same-cycle write to the read address forwards its value.
            if (bus.op_ram_enable_read) begin
                if (!op_in) begin
                    op_ram_value_q <= 1'b0;
                end else if (bus.op_ram_enable_write) begin
                    op_ram_value_q <= bus.op_ram_write_value;
                end else begin
                    op_ram_value_q <= mem[back_sel][op_idx];
                end
            end

            // A new error beats a simultaneous clear.
            if (op_err) begin
                range_error_q <= 1'b1;
            end else if (bus.err_clear) begin
                range_error_q <= 1'b0;
            end

            sx_q      <= sx;
            sy_q      <= sy;
            scan_en_q <= bus.scan_en;
            scan_in_q <= scan_in;

            scan_pixel_q <= (scan_en_q && scan_in_q) ? mem[front_sel_q][scan_idx] : 1'b0;
        end
    end

    assign bus.op_ram_value = op_ram_value_q;
    assign bus.scan_pixel   = scan_pixel_q;
    assign bus.swap_pending = (state_q == StPending);
    assign bus.front_sel    = front_sel_q;
    assign bus.range_error  = range_error_q;
endmodule

// File: tb/tb_gpu_framebuffer.sv
// Self-checking bench for gpu_framebuffer: table-driven GPU port vectors, directed
// multi-cycle sequences (line fill, swap, reset) and randomized traffic, all checked
// against a pixel-array reference model.
module tb_gpu_framebuffer;
    localparam int W = 320;
    localparam int H = 200;
    localparam int N = W * H;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    gpu_framebuffer_if bus();

    gpu_framebuffer #(
        .WIDTH   (320),
        .HEIGHT  (200),
        .SCALE_SH(1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: pixel arrays per buffer plus "known" flags, since memory
    // contents are undefined until written.
    bit m_mem   [2][N];
    bit m_known [2][N];
    bit m_rd_val, m_rd_known;
    bit m_scan, m_scan_known;
    bit m_err, m_pending, m_front;
    bit s_en, s_in;
    int s_off;

    typedef struct {
        int x;
        int y;
        bit rd;
        bit wr;
        bit wv;
        bit clr;
        bit exp_val;
        bit exp_err;
    } vec_t;
    vec_t tbl [15];

    task automatic chk(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic set_op(input int x, input int y, input bit rd, input bit wr, input bit wv);
        bus.op_x                = 9'(x);
        bus.op_y                = 8'(y);
        bus.op_ram_enable_read  = rd;
        bus.op_ram_enable_write = wr;
        bus.op_ram_write_value  = wv;
    endtask

    task automatic idle();
        bus.op_ram_enable_read  = 1'b0;
        bus.op_ram_enable_write = 1'b0;
        bus.scan_en             = 1'b0;
        bus.frame_start         = 1'b0;
        bus.swap_req            = 1'b0;
        bus.err_clear           = 1'b0;
    endtask

    // Advance one clock: update the model from the current inputs, then compare.
    task automatic step();
        int  x, y, sx, sy, off;
        bit  in_op, back;
        x = int'(bus.op_x);
        y = int'(bus.op_y);
        if (!rst_n) begin
            m_rd_val = 0; m_rd_known = 1; m_scan = 0; m_scan_known = 1;
            m_err = 0; m_pending = 0; m_front = 0;
            s_en = 0; s_in = 0; s_off = 0;
        end else begin
            in_op = (x < W) && (y < H);
            off   = y * W + x;
            back  = !m_front;
            if (s_en && s_in) begin
                m_scan       = m_mem[m_front][s_off];
                m_scan_known = m_known[m_front][s_off];
            end else begin
                m_scan = 0; m_scan_known = 1;
            end
            sx    = int'(bus.scan_x) / 2;
            sy    = int'(bus.scan_y) / 2;
            s_en  = bus.scan_en;
            s_in  = (sx < W) && (sy < H);
            s_off = sy * W + sx;
            if (bus.op_ram_enable_read) begin
                if (!in_op) begin
                    m_rd_val = 0; m_rd_known = 1;
                end else if (bus.op_ram_enable_write) begin
                    m_rd_val = bus.op_ram_write_value; m_rd_known = 1;
                end else begin
                    m_rd_val = m_mem[back][off]; m_rd_known = m_known[back][off];
                end
            end
            if (bus.op_ram_enable_write && in_op) begin
                m_mem[back][off]   = bus.op_ram_write_value;
                m_known[back][off] = 1;
            end
            if ((bus.op_ram_enable_read || bus.op_ram_enable_write) && !in_op) m_err = 1;
            else if (bus.err_clear) m_err = 0;
            if (m_pending && bus.frame_start) begin
                m_front = !m_front; m_pending = 0;
            end else if (bus.swap_req) begin
                m_pending = 1;
            end
        end
        @(posedge clk);
        #1;
        if (m_rd_known) chk("op_ram_value", bus.op_ram_value, m_rd_val);
        if (m_scan_known) chk("scan_pixel", bus.scan_pixel, m_scan);
        chk("range_error", bus.range_error, m_err);
        chk("swap_pending", bus.swap_pending, m_pending);
        chk("front_sel", bus.front_sel, m_front);
    endtask

    initial begin
        //            x    y    rd wr wv clr val err
        tbl[0]  = '{  5,   3,   0, 1, 1, 0,  0,  0};
        tbl[1]  = '{  5,   3,   1, 0, 0, 0,  1,  0};
        tbl[2]  = '{  5,   3,   0, 0, 0, 0,  1,  0};  // value holds without a read
        tbl[3]  = '{  6,   3,   1, 0, 0, 0,  0,  0};
        tbl[4]  = '{320,   0,   0, 1, 1, 0,  0,  1};
        tbl[5]  = '{  0,   0,   0, 0, 0, 1,  0,  0};
        tbl[6]  = '{  0,   1,   1, 0, 0, 0,  0,  0};  // suppressed write did not alias
        tbl[7]  = '{  5,   3,   1, 1, 0, 0,  0,  0};  // write-first
        tbl[8]  = '{  5,   3,   1, 1, 1, 0,  1,  0};
        tbl[9]  = '{  0, 200,   1, 0, 0, 0,  0,  1};
        tbl[10] = '{  0, 200,   1, 0, 0, 1,  0,  1};  // set beats clear
        tbl[11] = '{  0,   0,   0, 0, 0, 1,  0,  0};
        tbl[12] = '{319, 199,   1, 1, 1, 0,  1,  0};
        tbl[13] = '{319, 199,   1, 0, 0, 0,  1,  0};
        tbl[14] = '{319, 200,   1, 0, 0, 0,  0,  1};

        rst_n = 1'b0;
        idle();
        set_op(0, 0, 0, 0, 0);
        bus.scan_x = '0;
        bus.scan_y = '0;
        step();
        chk("reset_op_ram_value", bus.op_ram_value, 1'b0);
        chk("reset_scan_pixel", bus.scan_pixel, 1'b0);
        chk("reset_front_sel", bus.front_sel, 1'b0);
        step();
        rst_n = 1'b1;

        // Bring lines 0..15 of the back buffer to a known zero state.
        for (int y = 0; y < 16; y++) begin
            for (int x = 0; x < W; x++) begin
                set_op(x, y, 0, 1, 0);
                step();
            end
        end
        idle();

        // Table-driven GPU port vectors.
        for (int i = 0; i < 15; i++) begin
            set_op(tbl[i].x, tbl[i].y, tbl[i].rd, tbl[i].wr, tbl[i].wv);
            bus.err_clear = tbl[i].clr;
            step();
            chk($sformatf("vec%0d_value", i), bus.op_ram_value, tbl[i].exp_val);
            chk($sformatf("vec%0d_error", i), bus.range_error, tbl[i].exp_err);
        end
        idle();

        // Back-to-back fill of line 10, then read back lines 9..11.
        for (int x = 0; x < W; x++) begin
            set_op(x, 10, 0, 1, 1);
            step();
        end
        for (int x = 0; x < W; x++) begin
            set_op(x, 10, 1, 0, 0);
            step();
            chk("line10_readback", bus.op_ram_value, 1'b1);
        end
        for (int k = 0; k < 3; k++) begin
            set_op(k * 159, 9, 1, 0, 0);
            step();
            chk("line9_untouched", bus.op_ram_value, 1'b0);
            set_op(k * 159, 11, 1, 0, 0);
            step();
            chk("line11_untouched", bus.op_ram_value, 1'b0);
        end
        idle();

        // Swap after 100 cycles; write in the toggle cycle still hits the old back buffer.
        set_op(7, 7, 0, 1, 1);
        step();
        idle();
        bus.swap_req = 1'b1;
        step();
        bus.swap_req = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            chk("swap_pending_wait", bus.swap_pending, 1'b1);
            chk("front_sel_wait", bus.front_sel, 1'b0);
        end
        bus.frame_start = 1'b1;
        set_op(8, 8, 0, 1, 1);
        step();
        idle();
        chk("swap_done_front", bus.front_sel, 1'b1);
        chk("swap_done_pending", bus.swap_pending, 1'b0);
        bus.scan_x = 10'd14; bus.scan_y = 10'd14; bus.scan_en = 1'b1;
        step();
        bus.scan_x = 10'd16; bus.scan_y = 10'd16;
        step();
        chk("scan_7_7", bus.scan_pixel, 1'b1);
        bus.scan_en = 1'b0;
        step();
        chk("scan_8_8_toggle_write", bus.scan_pixel, 1'b1);
        step();
        chk("scan_disabled", bus.scan_pixel, 1'b0);

        // Double request gives one toggle; coincident request+frame_start defers.
        bus.swap_req = 1'b1;
        step();
        step();
        bus.swap_req = 1'b0;
        bus.frame_start = 1'b1;
        step();
        chk("double_req_toggle", bus.front_sel, 1'b0);
        step();
        chk("no_second_toggle", bus.front_sel, 1'b0);
        bus.swap_req = 1'b1;
        step();
        bus.swap_req = 1'b0;
        bus.frame_start = 1'b0;
        chk("coincident_no_toggle", bus.front_sel, 1'b0);
        chk("coincident_pending", bus.swap_pending, 1'b1);
        step();
        bus.frame_start = 1'b1;
        step();
        bus.frame_start = 1'b0;
        chk("deferred_toggle", bus.front_sel, 1'b1);

        // Reset while a swap is pending and a read is issued.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        bus.swap_req = 1'b1;
        step();
        bus.swap_req = 1'b0;
        chk("pending_before_reset", bus.swap_pending, 1'b1);
        set_op(7, 7, 1, 0, 0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        idle();
        chk("rst_front_sel", bus.front_sel, 1'b0);
        chk("rst_swap_pending", bus.swap_pending, 1'b0);
        chk("rst_op_ram_value", bus.op_ram_value, 1'b0);
        bus.frame_start = 1'b1;
        step();
        bus.frame_start = 1'b0;
        chk("dropped_swap", bus.front_sel, 1'b0);
        set_op(7, 7, 1, 0, 0);
        step();
        chk("mem_kept_over_reset", bus.op_ram_value, 1'b1);
        idle();

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 9);
            bus.op_x = (r == 0) ? 9'($urandom_range(316, 330)) : 9'($urandom_range(0, 31));
            bus.op_y = (r == 1) ? 8'($urandom_range(196, 210)) : 8'($urandom_range(0, 15));
            bus.op_ram_enable_read  = 1'($urandom_range(0, 1));
            bus.op_ram_enable_write = ($urandom_range(0, 2) == 0);
            bus.op_ram_write_value  = 1'($urandom_range(0, 1));
            r = $urandom_range(0, 9);
            bus.scan_x = (r == 0) ? 10'($urandom_range(630, 700)) : 10'($urandom_range(0, 63));
            bus.scan_y = (r == 1) ? 10'($urandom_range(395, 420)) : 10'($urandom_range(0, 31));
            bus.scan_en     = 1'($urandom_range(0, 1));
            bus.frame_start = ($urandom_range(0, 19) == 0);
            bus.swap_req    = ($urandom_range(0, 9) == 0);
            bus.err_clear   = ($urandom_range(0, 15) == 0);
            step();
        end
        idle();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
